// File: rtl/seg_display_monitor.sv
// ============================================================================
// Module      : seg_display_monitor
// Description : Decodes a two-digit active-low 7-segment bus back to binary
//               after a stability filter; flags blank and illegal patterns.
//               Optional SEG_MON_SEQ_CHECK_EN adds a countdown sequence check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_display_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [13:0]          seg_in,
    input  logic                 sample_en,
    input  logic                 clear_err,
    output logic [6:0]           value,
    output logic                 value_valid,
    output logic                 blank,
    output logic                 error,
    output logic                 update,
`ifdef SEG_MON_SEQ_CHECK_EN
    output logic                 seq_err,
`endif
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_STABLE = CNT_W'(STABLE_CYCLES);
    localparam logic [13:0]      c_BLANK  = 14'h3FFF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_LOCKED = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [13:0]            r_cand;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [13:0]            r_last_pat;
    logic                   r_committed;
    logic [6:0]             r_value;
    logic                   r_valid, r_blank, r_error, r_update;
    logic [ERR_CNT_W-1:0]   r_err_cnt;

    logic                   w_diff, w_commit, w_blank, w_legal, w_illegal;
    logic [4:0]             w_tens, w_ones;
    logic [6:0]             w_value;

    // Returns {digit_ok, digit}
    function automatic logic [4:0] f_decode(input logic [6:0] p);
        case (p)
            7'b0000001: f_decode = {1'b1, 4'd0};
            7'b1001111: f_decode = {1'b1, 4'd1};
            7'b0010010: f_decode = {1'b1, 4'd2};
            7'b0000110: f_decode = {1'b1, 4'd3};
            7'b1001100: f_decode = {1'b1, 4'd4};
            7'b0100100: f_decode = {1'b1, 4'd5};
            7'b0100000: f_decode = {1'b1, 4'd6};
            7'b0001111: f_decode = {1'b1, 4'd7};
            7'b0000000: f_decode = {1'b1, 4'd8};
            7'b0000100: f_decode = {1'b1, 4'd9};
            default:    f_decode = 5'd0;
        endcase
    endfunction

    assign w_tens    = f_decode(seg_in[13:7]);
    assign w_ones    = f_decode(seg_in[6:0]);
    assign w_blank   = (seg_in == c_BLANK);
    assign w_legal   = w_tens[4] && w_ones[4] && (w_tens[3:0] <= 4'd6);
    assign w_illegal = !w_blank && !w_legal;
    assign w_value   = 7'(w_tens[3:0]) * 7'd10 + 7'(w_ones[3:0]);

    assign w_diff    = (seg_in != r_cand);
    assign w_cnt_nxt = w_diff ? CNT_W'(1) :
                       (r_cnt < c_STABLE) ? r_cnt + 1'b1 : r_cnt;
    // Commit only on the edge the counter arrives at the threshold, never while parked there
    assign w_commit  = sample_en && (w_cnt_nxt == c_STABLE) &&
                       (w_diff || (r_cnt != c_STABLE));

    always_comb begin
        w_state_nxt = r_state;
        if (sample_en) begin
            if (w_commit)
                w_state_nxt = w_illegal ? S_FAULT : S_LOCKED;
            else if (w_diff)
                w_state_nxt = S_SETTLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cand      <= c_BLANK;
            r_cnt       <= '0;
            r_last_pat  <= c_BLANK;
            r_committed <= 1'b0;
            r_value     <= '0;
            r_valid     <= 1'b0;
            r_blank     <= 1'b0;
            r_error     <= 1'b0;
            r_update    <= 1'b0;
        end else begin
            r_update <= 1'b0;
            if (sample_en) begin
                r_state <= w_state_nxt;
                r_cand  <= seg_in;
                r_cnt   <= w_cnt_nxt;
                if (w_commit) begin
                    r_update    <= !r_committed || (seg_in != r_last_pat);
                    r_last_pat  <= seg_in;
                    r_committed <= 1'b1;
                    r_valid     <= w_legal;
                    r_blank     <= w_blank;
                    r_error     <= w_illegal;
                    if (w_legal)
                        r_value <= w_value;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err_cnt <= '0;
        else if (clear_err)
            r_err_cnt <= '0;
        else if (w_commit && w_illegal && (r_err_cnt != '1))
            r_err_cnt <= r_err_cnt + 1'b1;
    end

`ifdef SEG_MON_SEQ_CHECK_EN
    logic       r_seq_err;
    logic       r_prev_legal;
    logic [6:0] r_prev_val;

    // A blank commit arms a reload; illegal commits leave the history untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seq_err    <= 1'b0;
            r_prev_legal <= 1'b0;
            r_prev_val   <= '0;
        end else begin
            r_seq_err <= 1'b0;
            if (w_commit) begin
                if (w_legal) begin
                    r_seq_err    <= r_prev_legal && (r_prev_val != 7'd0) &&
                                    (w_value != r_prev_val - 7'd1);
                    r_prev_legal <= 1'b1;
                    r_prev_val   <= w_value;
                end else if (w_blank) begin
                    r_prev_legal <= 1'b0;
                end
            end
        end
    end

    assign seq_err = r_seq_err;
`endif

    assign value       = r_value;
    assign value_valid = r_valid;
    assign blank       = r_blank;
    assign error       = r_error;
    assign update      = r_update;
    assign err_count   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_seg_display_monitor.sv
// ============================================================================
// Module      : tb_seg_display_monitor
// Description : Directed vector table plus hand sequences for seg_display_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_display_monitor;

    localparam logic [13:0] P00   = 14'b0000001_0000001;
    localparam logic [13:0] P59   = 14'b0100100_0000100;
    localparam logic [13:0] PBLK  = 14'h3FFF;
    localparam logic [13:0] P69   = 14'b0100000_0000100;
    localparam logic [13:0] P47   = 14'b1001100_0001111;
    localparam logic [13:0] PT70  = 14'b0001111_0000001;
    localparam logic [13:0] P12   = 14'b1001111_0010010;
    localparam logic [13:0] PHB3  = 14'b1111111_0000110;
    localparam logic [13:0] P38   = 14'b0000110_0000000;
    localparam logic [13:0] P23   = 14'b0010010_0000110;
    localparam logic [13:0] P45   = 14'b1001100_0100100;
    localparam logic [13:0] P22   = 14'b0010010_0010010;
    localparam logic [13:0] P20   = 14'b0010010_0000001;
    localparam logic [13:0] PIA   = 14'b0000001_1111110;
    localparam logic [13:0] PIB   = 14'b1111111_1111110;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] seg_in;
    logic        sample_en;
    logic        clear_err;
    logic [6:0]  value;
    logic        value_valid, blank, error, update;
    logic [7:0]  err_count;
`ifdef SEG_MON_SEQ_CHECK_EN
    logic        seq_err;
`endif

    int tests = 0;
    int fails = 0;
    int upd_cnt;
    int seq_cnt;

    always #5 clk = ~clk;

    seg_display_monitor #(.STABLE_CYCLES(4), .ERR_CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .seg_in(seg_in),
        .sample_en(sample_en),
        .clear_err(clear_err),
        .value(value),
        .value_valid(value_valid),
        .blank(blank),
        .error(error),
        .update(update),
`ifdef SEG_MON_SEQ_CHECK_EN
        .seq_err(seq_err),
`endif
        .err_count(err_count)
    );

    typedef struct {
        logic [13:0] seg;
        int          hold;
        logic [6:0]  exp_val;
        logic        exp_valid;
        logic        exp_blank;
        logic        exp_error;
        logic [7:0]  exp_errcnt;
        int          exp_upd;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive a pattern for n clocks, observing pulses on each falling edge
    task automatic hold(input logic [13:0] pat, input int n, input logic en);
        upd_cnt = 0;
        seq_cnt = 0;
        for (int i = 0; i < n; i++) begin
            seg_in    = pat;
            sample_en = en;
            @(posedge clk);
            @(negedge clk);
            if (update) upd_cnt++;
`ifdef SEG_MON_SEQ_CHECK_EN
            if (seq_err) seq_cnt++;
`endif
        end
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{P00,  4, 7'd0,  1'b1, 1'b0, 1'b0, 8'd0, 1};
        vecs[1] = '{P00,  4, 7'd0,  1'b1, 1'b0, 1'b0, 8'd0, 0};
        vecs[2] = '{P59,  4, 7'd59, 1'b1, 1'b0, 1'b0, 8'd0, 1};
        vecs[3] = '{PBLK, 4, 7'd59, 1'b0, 1'b1, 1'b0, 8'd0, 1};
        vecs[4] = '{P69,  4, 7'd69, 1'b1, 1'b0, 1'b0, 8'd0, 1};
        vecs[5] = '{P47,  4, 7'd47, 1'b1, 1'b0, 1'b0, 8'd0, 1};
        vecs[6] = '{PT70, 4, 7'd47, 1'b0, 1'b0, 1'b1, 8'd1, 1};
        vecs[7] = '{P12,  4, 7'd12, 1'b1, 1'b0, 1'b0, 8'd1, 1};
        vecs[8] = '{PHB3, 4, 7'd12, 1'b0, 1'b0, 1'b1, 8'd2, 1};
        vecs[9] = '{P38,  4, 7'd38, 1'b1, 1'b0, 1'b0, 8'd2, 1};

        rst = 1'b1;
        seg_in = P00;
        sample_en = 1'b0;
        clear_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_value", value, 0);
        chk("rst_valid", value_valid, 0);
        chk("rst_blank", blank, 0);
        chk("rst_error", error, 0);
        chk("rst_update", update, 0);
        chk("rst_errcnt", err_count, 0);
        rst = 1'b0;

        for (int v = 0; v < 10; v++) begin
            hold(vecs[v].seg, vecs[v].hold, 1'b1);
            chk($sformatf("v%0d_value", v), value, vecs[v].exp_val);
            chk($sformatf("v%0d_valid", v), value_valid, vecs[v].exp_valid);
            chk($sformatf("v%0d_blank", v), blank, vecs[v].exp_blank);
            chk($sformatf("v%0d_error", v), error, vecs[v].exp_error);
            chk($sformatf("v%0d_errcnt", v), err_count, vecs[v].exp_errcnt);
            chk($sformatf("v%0d_updates", v), upd_cnt, vecs[v].exp_upd);
        end

        // Commit latency: three samples are not enough, the fourth commits
        hold(P23, 3, 1'b1);
        chk("lat_before_value", value, 38);
        chk("lat_before_upd", upd_cnt, 0);
        hold(P23, 1, 1'b1);
        chk("lat_commit_value", value, 23);
        chk("lat_commit_upd", update, 1);
        hold(P23, 1, 1'b1);
        chk("lat_upd_single", update, 0);

        // Short glitch never commits
        hold(P59, 2, 1'b1);
        chk("glitch_value", value, 23);
        chk("glitch_upd", upd_cnt, 0);
        hold(P23, 4, 1'b1);
        chk("glitch_back_value", value, 23);
        chk("glitch_back_upd", upd_cnt, 0);

        // sample_en low freezes everything
        hold(P12, 6, 1'b0);
        chk("noen_value", value, 23);
        chk("noen_upd", upd_cnt, 0);

        // Error counter saturation from 2 upward
        for (int i = 0; i < 300; i++)
            hold((i % 2 == 0) ? PIA : PIB, 4, 1'b1);
        chk("sat_errcnt", err_count, 255);
        chk("sat_error", error, 1);
        chk("sat_value", value, 23);

        // Clear wins over a simultaneous illegal commit
        hold(PIA, 3, 1'b1);
        seg_in = PIA;
        clear_err = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear_err = 1'b0;
        chk("clr_errcnt", err_count, 0);
        chk("clr_error", error, 1);
        hold(PIB, 4, 1'b1);
        chk("after_clr_errcnt", err_count, 1);

        // Asynchronous reset mid-settle
        hold(P45, 2, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_value", value, 0);
        chk("mid_rst_error", error, 0);
        chk("mid_rst_errcnt", err_count, 0);
        chk("mid_rst_valid", value_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        hold(P45, 3, 1'b1);
        chk("post_rst_early", value_valid, 0);
        hold(P45, 1, 1'b1);
        chk("post_rst_value", value, 45);
        chk("post_rst_upd", upd_cnt, 1);

`ifdef SEG_MON_SEQ_CHECK_EN
        hold(PBLK, 4, 1'b1);
        hold(P23, 4, 1'b1);
        chk("seq_23", seq_cnt, 0);
        hold(P22, 4, 1'b1);
        chk("seq_22", seq_cnt, 0);
        hold(P20, 4, 1'b1);
        chk("seq_20", seq_cnt, 1);
        hold(PBLK, 4, 1'b1);
        hold(P00, 4, 1'b1);
        chk("seq_00", seq_cnt, 0);
        hold(P59, 4, 1'b1);
        chk("seq_59", seq_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
